// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide engine: shift-add multiply and restoring
// divide, BITS_PER_CYCLE bits retired per iteration, sign fix-up on the last step.
module muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]      count;
    logic [2:0]         op_q;
    logic               neg_q, neg_r;
    logic [2*WIDTH-1:0] acc, mcand, acc_nx, prod_f;
    logic [WIDTH-1:0]   mplier, rem, quo, divisor;
    logic [WIDTH-1:0]   rem_nx, quo_nx, quo_f, rem_f, res_fin;
    logic [WIDTH:0]     trial;

    // operand decode at the accepting edge
    logic             a_sgn, b_sgn, neg_a, neg_b, div_zero, div_ovf, special, accept, last;
    logic [WIDTH-1:0] mag_a, mag_b, special_res;

    assign a_sgn    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_sgn    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign neg_a    = a_sgn & a[WIDTH-1];
    assign neg_b    = b_sgn & b[WIDTH-1];
    assign mag_a    = neg_a ? -a : a;
    assign mag_b    = neg_b ? -b : b;
    assign div_zero = op[2] && (b == '0);
    assign div_ovf  = op[2] && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
    assign special  = div_zero | div_ovf;
    assign special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    assign accept   = start && !flush && (state != CALC);
    assign last     = (count == CW'(ITER-1));
    assign busy     = (state == CALC);
    assign done     = (state == DONE);

    // one iteration of both datapaths; op_q picks which one matters at the end
    always_comb begin
        acc_nx = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            if (mplier[i]) acc_nx = acc_nx + (mcand << i);
        rem_nx = rem;
        quo_nx = quo;
        trial  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            trial  = {rem_nx, quo_nx[WIDTH-1]};
            quo_nx = {quo_nx[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, divisor}) begin
                trial     = trial - {1'b0, divisor};
                quo_nx[0] = 1'b1;
            end
            rem_nx = trial[WIDTH-1:0];
        end
        prod_f = neg_q ? -acc_nx : acc_nx;
        quo_f  = neg_q ? -quo_nx : quo_nx;
        rem_f  = neg_r ? -rem_nx : rem_nx;
        case (op_q)
            3'b000:                 res_fin = prod_f[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: res_fin = prod_f[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         res_fin = quo_f;
            default:                res_fin = rem_f;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = accept ? (special ? DONE : CALC) : IDLE;
            CALC:       state_nx = last ? DONE : CALC;
            default:    state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            result  <= '0;
        end else if (accept) begin
            count   <= '0;
            op_q    <= op;
            neg_q   <= neg_a ^ neg_b;
            neg_r   <= neg_a;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            mplier  <= mag_b;
            rem     <= '0;
            quo     <= mag_a;
            divisor <= mag_b;
            if (special) result <= special_res;
        end else if (state == CALC && !flush) begin
            count  <= count + 1'b1;
            acc    <= acc_nx;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            rem    <= rem_nx;
            quo    <= quo_nx;
            if (last) result <= res_fin;
        end
    end
endmodule
